clock_mode_controller: RTL and testbench

//   Timekeeping and alarm sequencer that feeds the 4-digit multiplexed time display.
//   It keeps HH:MM:SS and an alarm HH:MM, and runs a mode FSM for setting the time and the alarm.
//   It drives the BCD digits H1/H2/M1/M2 and per-digit blanking to the display block, and drives alarm_on.

---
 rtl/clock_mode_controller_if.sv | 26 ++
 rtl/clock_mode_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_clock_mode_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_mode_controller_if.sv
// Button/tick inputs and BCD display outputs of the clock mode controller.
// The master drives buttons and tick; the slave (controller) drives the display side.
interface clock_mode_controller_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       alarm_en;
  logic [1:0] H1;
  logic [3:0] H2;
  logic [2:0] M1;
  logic [3:0] M2;
  logic [3:0] blank;
  logic       alarm_on;
  logic [2:0] mode;

  modport master (
    output tick, btn_mode, btn_up, btn_down, alarm_en,
    input  H1, H2, M1, M2, blank, alarm_on, mode
  );

  modport slave (
    input  tick, btn_mode, btn_up, btn_down, alarm_en,
    output H1, H2, M1, M2, blank, alarm_on, mode
  );
endinterface

// File: rtl/clock_mode_controller.sv
// HH:MM:SS timekeeper with alarm and a button-driven mode FSM for setting
// time and alarm; drives BCD digits, per-digit blanking and the ring output.
module clock_mode_controller #(
  parameter int RING_SECS   = 60,
  parameter int ALARM_RST_H = 6,
  parameter int ALARM_RST_M = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  clock_mode_controller_if.slave bus
);

  typedef enum logic [2:0] {
    CLOCK    = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4,
    RING     = 3'd5
  } state_t;

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
  localparam logic [4:0] AHOUR_RST = 5'(ALARM_RST_H);
  localparam logic [5:0] AMIN_RST  = 6'(ALARM_RST_M);

  state_t     state_reg, state_next;
  logic [4:0] hour_reg, hour_next;
  logic [5:0] min_reg, min_next;
  logic [5:0] sec_reg, sec_next;
  logic [4:0] ahour_reg, ahour_next;
  logic [5:0] amin_reg, amin_next;
  logic       blink_reg, blink_next;
  logic [7:0] ring_cnt_reg, ring_cnt_next;

  logic       any_btn;
  logic       edit_up;
  logic       edit_down;
  logic       time_runs;
  logic       sec_roll;
  logic [5:0] run_sec;
  logic [5:0] run_min;
  logic [4:0] run_hour;
  logic       trigger;
  logic [4:0] src_hour;
  logic [5:0] src_min;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  // Simultaneous up+down cancels; mode takes precedence over both.
  assign any_btn   = bus.btn_mode | bus.btn_up | bus.btn_down;
  assign edit_up   = bus.btn_up & ~bus.btn_down & ~bus.btn_mode;
  assign edit_down = bus.btn_down & ~bus.btn_up & ~bus.btn_mode;
  assign time_runs = (state_reg == CLOCK) || (state_reg == SET_AHR) ||
                     (state_reg == SET_AMIN) || (state_reg == RING);

  always_comb begin
    sec_roll = (sec_reg == 6'd59);
    run_sec  = sec_roll ? 6'd0 : sec_reg + 6'd1;
    run_min  = min_reg;
    run_hour = hour_reg;
    if (sec_roll) begin
      run_min = wrap_inc(min_reg, 6'd59);
      if (min_reg == 6'd59) begin
        run_hour = 5'(wrap_inc({1'b0, hour_reg}, 6'd23));
      end
    end
  end

  // Only a seconds rollover in CLOCK can ring, so one minute yields one trigger.
  assign trigger = (state_reg == CLOCK) && bus.tick && bus.alarm_en && sec_roll &&
                   (run_hour == ahour_reg) && (run_min == amin_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLOCK;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLOCK: begin
        if (bus.btn_mode) begin
          state_next = SET_HR;
        end else if (trigger) begin
          state_next = RING;
        end
      end
      SET_HR:   if (bus.btn_mode) state_next = SET_MIN;
      SET_MIN:  if (bus.btn_mode) state_next = SET_AHR;
      SET_AHR:  if (bus.btn_mode) state_next = SET_AMIN;
      SET_AMIN: if (bus.btn_mode) state_next = CLOCK;
      RING: begin
        if (any_btn || !bus.alarm_en || (bus.tick && ring_cnt_reg == RING_LAST)) begin
          state_next = CLOCK;
        end
      end
      default: state_next = CLOCK;
    endcase
  end

  always_comb begin
    hour_next     = hour_reg;
    min_next      = min_reg;
    sec_next      = sec_reg;
    ahour_next    = ahour_reg;
    amin_next     = amin_reg;
    blink_next    = blink_reg ^ bus.tick;
    ring_cnt_next = ring_cnt_reg;

    // Entering SET_HR restarts the minute so the edited time starts at :00.
    if (state_reg == CLOCK && bus.btn_mode) begin
      sec_next = 6'd0;
    end else if (time_runs && bus.tick) begin
      sec_next  = run_sec;
      min_next  = run_min;
      hour_next = run_hour;
    end

    case (state_reg)
      SET_HR: begin
        if (edit_up)   hour_next = 5'(wrap_inc({1'b0, hour_reg}, 6'd23));
        if (edit_down) hour_next = 5'(wrap_dec({1'b0, hour_reg}, 6'd23));
      end
      SET_MIN: begin
        if (edit_up)   min_next = wrap_inc(min_reg, 6'd59);
        if (edit_down) min_next = wrap_dec(min_reg, 6'd59);
      end
      SET_AHR: begin
        if (edit_up)   ahour_next = 5'(wrap_inc({1'b0, ahour_reg}, 6'd23));
        if (edit_down) ahour_next = 5'(wrap_dec({1'b0, ahour_reg}, 6'd23));
      end
      SET_AMIN: begin
        if (edit_up)   amin_next = wrap_inc(amin_reg, 6'd59);
        if (edit_down) amin_next = wrap_dec(amin_reg, 6'd59);
      end
      default: ;
    endcase

    if (trigger) begin
      ring_cnt_next = 8'd0;
    end else if (state_reg == RING && bus.tick) begin
      ring_cnt_next = ring_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_reg     <= 5'd0;
      min_reg      <= 6'd0;
      sec_reg      <= 6'd0;
      ahour_reg    <= AHOUR_RST;
      amin_reg     <= AMIN_RST;
      blink_reg    <= 1'b0;
      ring_cnt_reg <= 8'd0;
    end else begin
      hour_reg     <= hour_next;
      min_reg      <= min_next;
      sec_reg      <= sec_next;
      ahour_reg    <= ahour_next;
      amin_reg     <= amin_next;
      blink_reg    <= blink_next;
      ring_cnt_reg <= ring_cnt_next;
    end
  end

  always_comb begin
    src_hour = hour_reg;
    src_min  = min_reg;
    if (state_reg == SET_AHR || state_reg == SET_AMIN) begin
      src_hour = ahour_reg;
      src_min  = amin_reg;
    end

    if (src_hour >= 5'd20) begin
      bus.H1 = 2'd2;
      bus.H2 = 4'(src_hour - 5'd20);
    end else if (src_hour >= 5'd10) begin
      bus.H1 = 2'd1;
      bus.H2 = 4'(src_hour - 5'd10);
    end else begin
      bus.H1 = 2'd0;
      bus.H2 = 4'(src_hour);
    end

    if (src_min >= 6'd50) begin
      bus.M1 = 3'd5;
      bus.M2 = 4'(src_min - 6'd50);
    end else if (src_min >= 6'd40) begin
      bus.M1 = 3'd4;
      bus.M2 = 4'(src_min - 6'd40);
    end else if (src_min >= 6'd30) begin
      bus.M1 = 3'd3;
      bus.M2 = 4'(src_min - 6'd30);
    end else if (src_min >= 6'd20) begin
      bus.M1 = 3'd2;
      bus.M2 = 4'(src_min - 6'd20);
    end else if (src_min >= 6'd10) begin
      bus.M1 = 3'd1;
      bus.M2 = 4'(src_min - 6'd10);
    end else begin
      bus.M1 = 3'd0;
      bus.M2 = 4'(src_min);
    end

    bus.blank = 4'b0000;
    if (blink_reg) begin
      if (state_reg == SET_HR || state_reg == SET_AHR) begin
        bus.blank = 4'b1100;
      end else if (state_reg == SET_MIN || state_reg == SET_AMIN) begin
        bus.blank = 4'b0011;
      end
    end

    bus.alarm_on = (state_reg == RING);
    bus.mode     = state_reg;
  end

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller: setting, rollover, alarm ring,
// auto-stop, blinking and reset, with hand-computed expected values.
module tb_clock_mode_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic blink_exp = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   waited;

  always #5 clk = ~clk;

  clock_mode_controller_if bus();

  clock_mode_controller #(
    .RING_SECS  (3),
    .ALARM_RST_H(6),
    .ALARM_RST_M(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
      $display("check %s: got %0d expected %0d ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int hhmm();
    return int'(bus.H1) * 1000 + int'(bus.H2) * 100 + int'(bus.M1) * 10 + int'(bus.M2);
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic t, input logic m, input logic u, input logic d);
    bus.tick     = t;
    bus.btn_mode = m;
    bus.btn_up   = u;
    bus.btn_down = d;
    @(posedge clk);
    #1;
    bus.tick     = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    if (t && !rst) blink_exp = ~blink_exp;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_mode(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic up_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic down_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.tick     = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.alarm_en = 1'b0;

    // Reset
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    blink_exp = 1'b0;
    check("rst_time", hhmm(), 0);
    check("rst_alarm_on", int'(bus.alarm_on), 0);
    check("rst_mode", int'(bus.mode), 0);
    check("rst_blank", int'(bus.blank), 0);

    // Set 23:59 and roll over; alarm at 06:00 must stay silent
    bus.alarm_en = 1'b1;
    press_mode(1);
    check("set_hr_mode", int'(bus.mode), 1);
    down_n(1);
    check("hr_down_wrap", hhmm(), 2300);
    press_mode(1);
    check("set_min_mode", int'(bus.mode), 2);
    down_n(1);
    check("min_down_wrap", hhmm(), 2359);
    press_mode(1);
    check("set_ahr_mode", int'(bus.mode), 3);
    check("ahr_shows_alarm", hhmm(), 600);
    press_mode(2);
    check("back_to_clock", int'(bus.mode), 0);
    check("clock_shows_time", hhmm(), 2359);
    ticks(59);
    check("before_rollover", hhmm(), 2359);
    ticks(1);
    check("rollover", hhmm(), 0);
    check("rollover_no_alarm", int'(bus.alarm_on), 0);

    // Editing hours: seconds forced to 0, time frozen, blink, up+down
    ticks(30);
    press_mode(1);
    check("edit_hr_entry", hhmm(), 0);
    down_n(1);
    check("edit_hr_down0", hhmm(), 2300);
    up_n(1);
    check("edit_hr_up23", hhmm(), 0);
    up_n(13);
    check("edit_hr_13", hhmm(), 1300);
    for (int i = 0; i < 5; i++) begin
      ticks(1);
      check("frozen_time", hhmm(), 1300);
      check("blank_hr", int'(bus.blank), blink_exp ? 12 : 0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("up_down_same", hhmm(), 1300);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("mode_up_mode", int'(bus.mode), 2);
    check("mode_up_time", hhmm(), 1300);
    down_n(1);
    check("edit_min_59", hhmm(), 1359);
    press_mode(3);
    check("clock_again", int'(bus.mode), 0);
    ticks(59);
    check("secs_were_zero", hhmm(), 1359);
    ticks(1);
    check("minute_carry", hhmm(), 1400);

    // Alarm at 07:30, trigger from 07:29:59, cancel with btn_up
    press_mode(1);
    down_n(7);
    press_mode(1);
    up_n(29);
    check("time_0729", hhmm(), 729);
    press_mode(1);
    up_n(1);
    check("alarm_hr_7", hhmm(), 700);
    press_mode(1);
    up_n(30);
    check("alarm_0730", hhmm(), 730);
    press_mode(1);
    check("clock_0729", hhmm(), 729);
    ticks(59);
    check("no_ring_yet", int'(bus.alarm_on), 0);
    ticks(1);
    check("ring_on", int'(bus.alarm_on), 1);
    check("ring_mode", int'(bus.mode), 5);
    check("ring_time", hhmm(), 730);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("btn_cancel", int'(bus.alarm_on), 0);
    check("btn_cancel_mode", int'(bus.mode), 0);
    check("btn_no_edit", hhmm(), 730);

    // Auto-stop after 3 ticks with alarm 07:31
    press_mode(4);
    up_n(1);
    check("alarm_0731", hhmm(), 731);
    press_mode(1);
    ticks(60);
    check("ring2_on", int'(bus.alarm_on), 1);
    ticks(2);
    check("ring2_still", int'(bus.alarm_on), 1);
    ticks(1);
    check("auto_stop", int'(bus.alarm_on), 0);
    check("auto_stop_mode", int'(bus.mode), 0);
    check("auto_stop_time", hhmm(), 731);

    // alarm_en drop during RING, alarm 07:32
    press_mode(4);
    up_n(1);
    press_mode(1);
    ticks(60);
    check("ring3_on", int'(bus.alarm_on), 1);
    bus.alarm_en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("en_drop", int'(bus.alarm_on), 0);
    check("en_drop_mode", int'(bus.mode), 0);
    bus.alarm_en = 1'b1;

    // Blink in SET_AMIN, then reset mid-ring
    press_mode(4);
    check("amin_mode", int'(bus.mode), 4);
    for (int i = 0; i < 4; i++) begin
      ticks(1);
      check("blank_amin", int'(bus.blank), blink_exp ? 3 : 0);
      check("amin_shows_alarm", hhmm(), 732);
    end
    up_n(1);
    press_mode(1);
    waited = 0;
    while (waited < 100 && bus.alarm_on !== 1'b1) begin
      ticks(1);
      waited++;
    end
    check("ticks_to_ring", waited, 56);
    ticks(1);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    blink_exp = 1'b0;
    check("mid_ring_rst_alarm_on", int'(bus.alarm_on), 0);
    check("mid_ring_rst_mode", int'(bus.mode), 0);
    check("mid_ring_rst_time", hhmm(), 0);
    check("mid_ring_rst_blank", int'(bus.blank), 0);
    press_mode(3);
    check("rst_alarm_value", hhmm(), 600);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
